de_stage_buffer: RTL and testbench

Parametrised, handshaked pipeline register between Decode and Execute. It is the successor to the fixed-width D/E latch and adds:
- a valid/ready handshake with a one-entry skid register, so Decode never sees a combinational ready path from Execute;
- explicit bubble insertion;
- a flush that kills everything in flight.

Control, data payload, PC and the interrupt tag travel together as one entry.

---
 rtl/de_pkg.sv | 30 +++
 rtl/de_stage_buffer_entry.sv | 57 +++++
 rtl/de_stage_buffer.sv | 151 +++++++++++++++
 tb/tb_de_stage_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/de_pkg.sv
// de_pkg: definitions shared by the Decode/Execute stage buffer and by the
// stages that pack and unpack its payload.
//   - occ_e             : occupancy state encoding (EMPTY/MAIN/BOTH)
//   - *_W_DEF           : default bundle widths
//   - PAYLOAD_*_LSB/_W  : field positions inside the packed data payload
package de_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_BOTH  = 2'd2
    } occ_e;

    localparam int CTRL_W_DEF    = 15;
    localparam int PAYLOAD_W_DEF = 44;
    localparam int PC_W_DEF      = 32;

    // Payload layout, LSB first:
    //   function[3:0] | writeAdd2[2:0] | writeAdd1[2:0] | readData2[15:0] | readData1[15:0]
    // Bits above PAYLOAD_RD1_LSB+PAYLOAD_RD_W are spare and pass through untouched.
    localparam int PAYLOAD_FUNC_W   = 4;
    localparam int PAYLOAD_WADD_W   = 3;
    localparam int PAYLOAD_RD_W     = 16;
    localparam int PAYLOAD_FUNC_LSB = 0;
    localparam int PAYLOAD_WA2_LSB  = PAYLOAD_FUNC_LSB + PAYLOAD_FUNC_W;
    localparam int PAYLOAD_WA1_LSB  = PAYLOAD_WA2_LSB + PAYLOAD_WADD_W;
    localparam int PAYLOAD_RD2_LSB  = PAYLOAD_WA1_LSB + PAYLOAD_WADD_W;
    localparam int PAYLOAD_RD1_LSB  = PAYLOAD_RD2_LSB + PAYLOAD_RD_W;

endpackage

// File: rtl/de_stage_buffer_entry.sv
// stage_entry_reg: one {valid, ctrl, payload, pc, intr} pipeline entry.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (zeroes every field)
//   clear        : kill the entry (valid/ctrl/intr to 0, payload/pc hold)
//   load         : capture d_* and mark valid
//   bubble       : same effect as clear, used when the entry is consumed
//   d_*          : incoming entry fields
//   q_*          : registered entry fields
// Priority: rst > clear > load > bubble.
module stage_entry_reg
    import de_pkg::*;
#(
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int PC_W      = PC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 bubble,
    input  logic [CTRL_W-1:0]    d_ctrl,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic [PC_W-1:0]      d_pc,
    input  logic                 d_intr,
    output logic                 q_valid,
    output logic [CTRL_W-1:0]    q_ctrl,
    output logic [PAYLOAD_W-1:0] q_payload,
    output logic [PC_W-1:0]      q_pc,
    output logic                 q_intr
);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid   <= 1'b0;
            q_ctrl    <= '0;
            q_payload <= '0;
            q_pc      <= '0;
            q_intr    <= 1'b0;
        end else if (clear || (bubble && !load)) begin
            // Payload and PC deliberately hold: only the qualifying fields are
            // killed, which keeps the data path free of reset/clear muxing.
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            q_intr  <= 1'b0;
        end else if (load) begin
            q_valid   <= 1'b1;
            q_ctrl    <= d_ctrl;
            q_payload <= d_payload;
            q_pc      <= d_pc;
            q_intr    <= d_intr;
        end
    end

endmodule

// File: rtl/de_stage_buffer.sv
// de_stage_buffer: handshaked Decode->Execute pipeline register with a
// one-entry skid register, bubble insertion and flush.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   flush                  : kill all held entries and any entry offered this edge
//   in_valid / in_ready    : Decode-side handshake (in_ready is registered)
//   in_ctrl/payload/pc/intr: entry offered by Decode
//   out_valid / out_ready  : Execute-side handshake (out_valid is registered)
//   out_ctrl/payload/pc/intr: entry held in the main register
//   occupancy              : number of entries held, 0..2
module de_stage_buffer
    import de_pkg::*;
#(
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int PC_W      = PC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 in_intr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [PC_W-1:0]      out_pc,
    output logic                 out_intr,
    output logic [1:0]           occupancy
);

    occ_e state, state_nxt;

    logic accept, drain;
    logic main_load, main_from_skid, main_bubble;
    logic skid_load, skid_bubble;

    logic                 skid_valid;
    logic [CTRL_W-1:0]    skid_ctrl;
    logic [PAYLOAD_W-1:0] skid_payload;
    logic [PC_W-1:0]      skid_pc;
    logic                 skid_intr;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path through
    // the case statement leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_bubble    = 1'b0;
        skid_load      = 1'b0;
        skid_bubble    = 1'b0;
        unique case (state)
            OCC_EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_nxt = OCC_MAIN;
                end
            end
            OCC_MAIN: begin
                if (drain && accept) begin
                    main_load = 1'b1;
                end else if (drain) begin
                    main_bubble = 1'b1;
                    state_nxt   = OCC_EMPTY;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_nxt = OCC_BOTH;
                end
            end
            OCC_BOTH: begin
                if (drain && skid_valid) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_bubble    = 1'b1;
                    state_nxt      = OCC_MAIN;
                end
            end
            default: state_nxt = OCC_EMPTY;
        endcase
        // The entry registers see flush directly as their clear, so only the
        // occupancy needs overriding here.
        if (flush) begin
            state_nxt = OCC_EMPTY;
        end
    end

    // in_ready is computed from the next state and registered, so Decode never
    // sees a combinational path from out_ready or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OCC_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != OCC_BOTH);
        end
    end

    assign occupancy = state;

    stage_entry_reg #(
        .CTRL_W    (CTRL_W),
        .PAYLOAD_W (PAYLOAD_W),
        .PC_W      (PC_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (main_load),
        .bubble    (main_bubble),
        .d_ctrl    (main_from_skid ? skid_ctrl    : in_ctrl),
        .d_payload (main_from_skid ? skid_payload : in_payload),
        .d_pc      (main_from_skid ? skid_pc      : in_pc),
        .d_intr    (main_from_skid ? skid_intr    : in_intr),
        .q_valid   (out_valid),
        .q_ctrl    (out_ctrl),
        .q_payload (out_payload),
        .q_pc      (out_pc),
        .q_intr    (out_intr)
    );

    stage_entry_reg #(
        .CTRL_W    (CTRL_W),
        .PAYLOAD_W (PAYLOAD_W),
        .PC_W      (PC_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (skid_load),
        .bubble    (skid_bubble),
        .d_ctrl    (in_ctrl),
        .d_payload (in_payload),
        .d_pc      (in_pc),
        .d_intr    (in_intr),
        .q_valid   (skid_valid),
        .q_ctrl    (skid_ctrl),
        .q_payload (skid_payload),
        .q_pc      (skid_pc),
        .q_intr    (skid_intr)
    );

endmodule

// File: tb/tb_de_stage_buffer.sv
// tb_de_stage_buffer: directed scenarios followed by random traffic, all
// checked every cycle against a FIFO-of-entries reference model.
module tb_de_stage_buffer;
    import de_pkg::*;

    localparam int CW = CTRL_W_DEF;
    localparam int PW = PAYLOAD_W_DEF;
    localparam int AW = PC_W_DEF;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [PW-1:0] payload;
        logic [AW-1:0] pc;
        logic          intr;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready, in_intr;
    logic [CW-1:0] in_ctrl;
    logic [PW-1:0] in_payload;
    logic [AW-1:0] in_pc;
    logic          in_ready, out_valid, out_intr;
    logic [CW-1:0] out_ctrl;
    logic [PW-1:0] out_payload;
    logic [AW-1:0] out_pc;
    logic [1:0]    occupancy;

    de_stage_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_payload  (in_payload),
        .in_pc       (in_pc),
        .in_intr     (in_intr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_payload (out_payload),
        .out_pc      (out_pc),
        .out_intr    (out_intr),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: entries held in acceptance order, plus the payload/pc
    // last shown on the output (these hold across bubbles and flush).
    ent_t          q[$];
    logic [PW-1:0] hold_payload = '0;
    logic [AW-1:0] hold_pc      = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [CW-1:0] c, input logic [PW-1:0] p,
                                input logic [AW-1:0] a, input logic i);
        ent_t e;
        e.ctrl = c; e.payload = p; e.pc = a; e.intr = i;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk(CW'($urandom), {12'($urandom), 32'($urandom)}, AW'($urandom), 1'($urandom));
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare
    // every output on the following falling edge.
    task automatic cycle(input logic v, input ent_t e, input logic ordy,
                         input logic fl, input logic rs);
        bit model_ready;
        in_valid   = v;
        in_ctrl    = e.ctrl;
        in_payload = e.payload;
        in_pc      = e.pc;
        in_intr    = e.intr;
        out_ready  = ordy;
        flush      = fl;
        rst        = rs;
        model_ready = (q.size() < 2);
        @(posedge clk);
        if (rs) begin
            q.delete();
            hold_payload = '0;
            hold_pc      = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && model_ready) q.push_back(e);
        end
        if (q.size() > 0) begin
            hold_payload = q[0].payload;
            hold_pc      = q[0].pc;
        end
        @(negedge clk);
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("in_ready",  64'(in_ready),  64'(q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("out_payload", 64'(out_payload), 64'(hold_payload));
        check("out_pc",    64'(out_pc),    64'(hold_pc));
        if (q.size() > 0) begin
            check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
            check("out_intr", 64'(out_intr), 64'(q[0].intr));
        end else begin
            check("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
            check("out_intr_bubble", 64'(out_intr), 64'd0);
        end
    endtask

    ent_t idle;

    initial begin
        idle = mk('0, '0, '0, 1'b0);

        // Reset.
        cycle(0, idle, 0, 0, 1);
        cycle(0, idle, 0, 0, 1);
        cycle(0, idle, 0, 0, 0);

        // Streaming: 8 back-to-back entries with ctrl=i, pc=0x100+i.
        for (int i = 0; i < 8; i++)
            cycle(1, mk(CW'(i), PW'(i * 3 + 1), AW'(32'h100 + i), 1'b0), 1, 0, 0);
        cycle(0, idle, 1, 0, 0);

        // Back-pressure: stall after two entries, then drain.
        cycle(1, mk(15'h11, 44'h11, 32'h300, 1'b0), 1, 0, 0);
        cycle(1, mk(15'h12, 44'h12, 32'h301, 1'b0), 1, 0, 0);
        cycle(1, mk(15'h13, 44'h13, 32'h302, 1'b0), 0, 0, 0);
        cycle(1, mk(15'h14, 44'h14, 32'h303, 1'b0), 0, 0, 0);
        cycle(1, mk(15'h15, 44'h15, 32'h304, 1'b0), 0, 0, 0);
        cycle(0, idle, 1, 0, 0);
        cycle(0, idle, 1, 0, 0);
        cycle(0, idle, 1, 0, 0);

        // Flush from BOTH with all-ones ctrl and intr set, entry offered in the flush cycle.
        cycle(1, mk(15'h7FFF, 44'hA1, 32'h400, 1'b1), 0, 0, 0);
        cycle(1, mk(15'h7FFF, 44'hA2, 32'h401, 1'b1), 0, 0, 0);
        cycle(1, mk(15'h7FFF, 44'hA3, 32'h402, 1'b1), 0, 1, 0);
        cycle(0, idle, 1, 0, 0);

        // Flush together with drain while in MAIN.
        cycle(1, mk(15'h21, 44'hB1, 32'h500, 1'b0), 0, 0, 0);
        cycle(1, mk(15'h22, 44'hB2, 32'h501, 1'b0), 1, 1, 0);
        cycle(0, idle, 1, 0, 0);

        // Reset mid-stall, then a single entry at pc=0x200.
        cycle(1, mk(15'h31, 44'hC1, 32'h600, 1'b1), 0, 0, 0);
        cycle(1, mk(15'h32, 44'hC2, 32'h601, 1'b1), 0, 0, 0);
        cycle(1, mk(15'h33, 44'hC3, 32'h602, 1'b1), 0, 0, 1);
        cycle(1, mk(15'h34, 44'hC4, 32'h200, 1'b0), 1, 0, 0);
        cycle(0, idle, 1, 0, 0);

        // Bubble in the middle of a stream.
        cycle(1, mk(15'h41, 44'hD1, 32'h700, 1'b0), 1, 0, 0);
        cycle(0, idle, 1, 0, 0);
        cycle(1, mk(15'h42, 44'hD2, 32'h701, 1'b0), 1, 0, 0);
        cycle(0, idle, 1, 0, 0);

        // Random traffic with occasional flush and rare reset.
        for (int n = 0; n < 3000; n++)
            cycle(1'($urandom_range(0, 3) != 0), rnd_ent(),
                  1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
